// File: rtl/xbar_output_scheduler.sv
// ----------------------------------------------------------------------------
// xbar_output_scheduler
//
// Per-output wormhole arbiter for a five-port router crossbar. Each output
// stays locked to one input for a whole packet (head..tail). Between packets,
// a round-robin pointer per output picks which requester goes next.
// Decisions are made combinationally from the current cycle's inputs and are
// registered, so they drive the crossbar during the following cycle.
//
// Ports:
//   CLK             rising-edge clock
//   RST             asynchronous, active-high reset
//   in_request      bit [i*N_PORTS+j]: input i requests output j
//   in_tail         bit i: flit presented by input i is a tail
//   in_credit_avail bit j: downstream of output j has a free slot
//   out_grant       bit i: input i may send its flit this cycle (registered)
//   out_sel         bit [j*N_PORTS+i]: output j driven by input i (registered)
//   out_busy        bit j: output j is locked to a packet owner (registered)
// ----------------------------------------------------------------------------
module xbar_output_scheduler #(
  parameter int N_PORTS   = 5,
  parameter int PTR_WIDTH = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_PORTS*N_PORTS-1:0]   in_request,
  input  logic [N_PORTS-1:0]           in_tail,
  input  logic [N_PORTS-1:0]           in_credit_avail,
  output logic [N_PORTS-1:0]           out_grant,
  output logic [N_PORTS*N_PORTS-1:0]   out_sel,
  output logic [N_PORTS-1:0]           out_busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  logic [N_PORTS-1:0] norm_req [N_PORTS];  // [input] one-hot output choice
  logic [N_PORTS-1:0] cand     [N_PORTS];  // [output] inputs requesting it
  logic [N_PORTS-1:0] sel_d    [N_PORTS];  // [output] input granted next
  logic [N_PORTS-1:0] grant_d;
  logic [N_PORTS-1:0] grant_q;

  // Keep only the lowest-index output each input asks for; this is what makes
  // the per-output arbiters conflict-free without any cross-output logic.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_norm
    logic [N_PORTS-1:0] raw;
    assign raw         = in_request[i*N_PORTS +: N_PORTS];
    assign norm_req[i] = raw & (~raw + 1'b1);
  end

  // Transpose into per-output candidate vectors.
  for (genvar j = 0; j < N_PORTS; j++) begin : g_cand_row
    for (genvar i = 0; i < N_PORTS; i++) begin : g_cand_col
      assign cand[j][i] = norm_req[i][j];
    end
  end

  for (genvar j = 0; j < N_PORTS; j++) begin : g_out
    state_t               state_q, state_d;
    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic [PTR_WIDTH-1:0] owner_q, owner_d;
    logic [PTR_WIDTH-1:0] win;
    logic [PTR_WIDTH-1:0] idx;
    logic                 found;
    logic [N_PORTS-1:0]   sel_row_d, sel_row_q;

    always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      win       = owner_q;
      idx       = '0;
      found     = 1'b0;
      sel_row_d = '0;

      if (state_q == S_IDLE) begin
        // First requester at or above the pointer, wrapping modulo N_PORTS.
        for (int k = 0; k < N_PORTS; k++) begin
          idx = PTR_WIDTH'((int'(ptr_q) + k) % N_PORTS);
          if (!found && cand[j][idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
      end else begin
        // Locked: the owner is the only input that can be served.
        found = cand[j][owner_q];
      end

      if (found && in_credit_avail[j]) begin
        sel_row_d[win] = 1'b1;
        owner_d        = win;
        if (in_tail[win]) begin
          state_d = S_IDLE;
          ptr_d   = (win == PTR_WIDTH'(N_PORTS - 1)) ? '0 : win + PTR_WIDTH'(1);
        end else begin
          state_d = S_LOCKED;
        end
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q   <= S_IDLE;
        ptr_q     <= '0;
        owner_q   <= '0;
        sel_row_q <= '0;
      end else begin
        state_q   <= state_d;
        ptr_q     <= ptr_d;
        owner_q   <= owner_d;
        sel_row_q <= sel_row_d;
      end
    end

    assign sel_d[j]                        = sel_row_d;
    assign out_sel[j*N_PORTS +: N_PORTS]   = sel_row_q;
    assign out_busy[j]                     = (state_q == S_LOCKED);
  end

  // An input is granted if any output selected it (at most one can).
  for (genvar i = 0; i < N_PORTS; i++) begin : g_grant
    logic [N_PORTS-1:0] col;
    for (genvar j = 0; j < N_PORTS; j++) begin : g_grant_col
      assign col[j] = sel_d[j][i];
    end
    assign grant_d[i] = |col;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_q <= '0;
    end else begin
      grant_q <= grant_d;
    end
  end

  assign out_grant = grant_q;

endmodule

// File: tb/tb_xbar_output_scheduler.sv
module tb_xbar_output_scheduler;

  localparam int N  = 5;
  localparam int NN = N * N;

  logic          CLK;
  logic          RST;
  logic [NN-1:0] in_request;
  logic [N-1:0]  in_tail;
  logic [N-1:0]  in_credit_avail;
  logic [N-1:0]  out_grant;
  logic [NN-1:0] out_sel;
  logic [N-1:0]  out_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: per-output lock flag, owner and pointer.
  bit            m_locked [N];
  int            m_owner  [N];
  int            m_ptr    [N];
  logic [N-1:0]  exp_grant;
  logic [NN-1:0] exp_sel;
  logic [N-1:0]  exp_busy;

  xbar_output_scheduler #(.N_PORTS(N), .PTR_WIDTH(3)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .in_request      (in_request),
    .in_tail         (in_tail),
    .in_credit_avail (in_credit_avail),
    .out_grant       (out_grant),
    .out_sel         (out_sel),
    .out_busy        (out_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_locked[j] = 1'b0;
      m_owner[j]  = 0;
      m_ptr[j]    = 0;
    end
    exp_grant = '0;
    exp_sel   = '0;
    exp_busy  = '0;
  endtask

  // Advance the model by one decision using the inputs currently applied.
  task automatic model_step();
    int tgt [N];
    int w;
    for (int i = 0; i < N; i++) begin
      tgt[i] = -1;
      for (int j = N - 1; j >= 0; j--)
        if (in_request[i*N + j]) tgt[i] = j;
    end
    exp_grant = '0;
    exp_sel   = '0;
    for (int j = 0; j < N; j++) begin
      w = -1;
      if (m_locked[j]) begin
        if (tgt[m_owner[j]] == j) w = m_owner[j];
      end else begin
        for (int k = 0; k < N; k++)
          if (w < 0 && tgt[(m_ptr[j] + k) % N] == j) w = (m_ptr[j] + k) % N;
      end
      if (w >= 0 && in_credit_avail[j]) begin
        exp_grant[w]     = 1'b1;
        exp_sel[j*N + w] = 1'b1;
        m_owner[j]       = w;
        if (in_tail[w]) begin
          m_locked[j] = 1'b0;
          m_ptr[j]    = (w + 1) % N;
        end else begin
          m_locked[j] = 1'b1;
        end
      end
      exp_busy[j] = m_locked[j];
    end
  endtask

  task automatic clock_step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input int j);
    in_request[i*N + j] = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    in_request = '0; in_tail = '0; in_credit_avail = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({out_grant, out_sel, out_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got grant=%b sel=%b busy=%b, want all zero", out_grant, out_sel, out_busy);
    end
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      clock_step();
      n_checks++;
      if ({out_grant, out_sel, out_busy} !== '0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got grant=%b sel=%b busy=%b, want all zero", c, out_grant, out_sel, out_busy);
      end
    end
  endtask

  task automatic test_single_flit();
    in_credit_avail = '1;
    in_request = '0; set_req(2, 4);
    in_tail = 5'b00100;
    clock_step();
    n_checks++;
    if (out_grant !== 5'b00100 || out_sel !== (NN'(1) << 22) || out_busy[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_flit: got grant=%b sel=%h busy=%b, want grant=00100 sel=%h busy4=0", out_grant, out_sel, out_busy, NN'(1) << 22);
    end
    // Pointer now at 3: input 3 must beat input 2 for output 4.
    in_request = '0; set_req(2, 4); set_req(3, 4);
    in_tail = 5'b01100;
    clock_step();
    n_checks++;
    if (out_grant !== 5'b01000 || out_grant !== exp_grant) begin
      n_fail++;
      $display("FAIL single_flit_ptr: got grant=%b, want 01000 (model %b)", out_grant, exp_grant);
    end
    in_request = '0; in_tail = '0;
    clock_step();
  endtask

  task automatic test_wormhole();
    logic [N-1:0] want_g [4];
    logic [N-1:0] want_b [4];
    want_g = '{5'b00010, 5'b00010, 5'b00010, 5'b00001};
    want_b = '{5'b01000, 5'b01000, 5'b00000, 5'b00000};
    in_credit_avail = '1;
    for (int c = 0; c < 4; c++) begin
      in_request = '0;
      if (c < 3) set_req(1, 3);
      if (c > 0) set_req(0, 3);
      in_tail = (c == 2) ? 5'b00011 : 5'b00001;
      clock_step();
      n_checks++;
      if (out_grant !== want_g[c] || out_busy !== want_b[c] || out_sel !== exp_sel) begin
        n_fail++;
        $display("FAIL wormhole_c%0d: got grant=%b busy=%b sel=%h, want grant=%b busy=%b sel=%h",
                 c, out_grant, out_busy, out_sel, want_g[c], want_b[c], exp_sel);
      end
    end
    in_request = '0; in_tail = '0;
    clock_step();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want [6];
    want = '{5'b00001, 5'b00010, 5'b00100, 5'b00001, 5'b00010, 5'b00100};
    in_credit_avail = '1;
    in_request = '0; set_req(0, 0); set_req(1, 0); set_req(2, 0);
    in_tail = 5'b00111;
    for (int c = 0; c < 6; c++) begin
      clock_step();
      n_checks++;
      if (out_grant !== want[c] || out_sel !== exp_sel) begin
        n_fail++;
        $display("FAIL round_robin_c%0d: got grant=%b sel=%h, want grant=%b sel=%h", c, out_grant, out_sel, want[c], exp_sel);
      end
    end
    in_request = '0; in_tail = '0;
    clock_step();
  endtask

  task automatic test_credit_stall();
    // Input 4 sends a 8-flit packet to output 3; credit drops for cycles 2..5.
    for (int c = 0; c < 8; c++) begin
      in_request = '0; set_req(4, 3);
      in_tail = (c == 7) ? 5'b10000 : 5'b00000;
      in_credit_avail = (c >= 2 && c <= 5) ? 5'b10111 : 5'b11111;
      clock_step();
      n_checks++;
      if (out_grant !== ((c >= 2 && c <= 5) ? 5'b00000 : 5'b10000) ||
          out_busy[3] !== ((c == 7) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL credit_stall_c%0d: got grant=%b busy=%b", c, out_grant, out_busy);
      end
    end
    in_request = '0; in_tail = '0; in_credit_avail = '1;
    clock_step();
  endtask

  task automatic test_async_reset();
    in_credit_avail = '1;
    // Move ptr_3 to 3, then lock output 3 to input 4.
    in_request = '0; set_req(2, 3); in_tail = 5'b00100;
    clock_step();
    in_request = '0; set_req(4, 3); in_tail = 5'b00000;
    clock_step();
    n_checks++;
    if (out_busy[3] !== 1'b1 || out_grant !== 5'b10000) begin
      n_fail++;
      $display("FAIL async_pre_lock: got grant=%b busy=%b, want grant=10000 busy3=1", out_grant, out_busy);
    end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({out_grant, out_sel, out_busy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got grant=%b sel=%h busy=%b, want all zero before clock edge", out_grant, out_sel, out_busy);
    end
    #1 RST = 1'b0;
    model_reset();
    in_request = '0; set_req(1, 3); set_req(4, 3); in_tail = 5'b10010;
    clock_step();
    n_checks++;
    if (out_grant !== 5'b00010 || out_busy !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_post_ptr0: got grant=%b busy=%b, want grant=00010 busy=00000", out_grant, out_busy);
    end
    in_request = '0; in_tail = '0;
    clock_step();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    for (int c = 0; c < 300; c++) begin
      in_request = '0;
      for (int i = 0; i < N; i++) begin
        r = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom_range(1, 31));
        in_request[i*N +: N] = r;
      end
      in_tail = 5'($urandom_range(0, 31));
      for (int j = 0; j < N; j++) in_credit_avail[j] = ($urandom_range(0, 4) != 0);
      clock_step();
      n_checks++;
      if (out_grant !== exp_grant || out_sel !== exp_sel || out_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL random_c%0d: got grant=%b sel=%h busy=%b, want grant=%b sel=%h busy=%b",
                 c, out_grant, out_sel, out_busy, exp_grant, exp_sel, exp_busy);
      end
    end
    in_request = '0; in_tail = '0;
    clock_step();
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_wormhole();
    test_round_robin();
    test_credit_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xbar_output_scheduler.md
Name: xbar_output_scheduler

Overview:
- Per-output wormhole arbiter that shares each router output port among the five input channels.
- Takes per-input output requests, tail indicators and downstream credit availability.
- Locks each output to one input for the whole packet, with round-robin fairness between packets.
- Produces registered per-input grants and a registered one-hot select matrix that configures the crossbar for the next cycle.

Parameters:
- N_PORTS, 5, number of router ports; each port is one input and one output, index 0 is local.
- PTR_WIDTH, 3, width of the round-robin pointer; must satisfy 2^PTR_WIDTH >= N_PORTS.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- in_request  input  N_PORTS*N_PORTS  bit [i*N_PORTS+j]: input i requests output j this cycle.
- in_tail  input  N_PORTS  bit i: the flit input i currently presents is a tail (single-flit packets assert head and tail together).
- in_credit_avail  input  N_PORTS  bit j: downstream of output j has at least one free buffer slot.
- out_grant  output  N_PORTS  bit i: input i may send its flit this cycle (registered).
- out_sel  output  N_PORTS*N_PORTS  bit [j*N_PORTS+i]: output j is driven by input i this cycle; at most one bit set per j (registered).
- out_busy  output  N_PORTS  bit j: output j is locked to a packet owner (registered).

Behaviour:
- Reset: out_grant=0, out_sel=0, out_busy=0, all owner registers=0, all pointers=0.
- Reset is asynchronous. Asserting it mid-packet drops every lock immediately; there is no recovery of partial packets.
- Request normalisation: if input i sets more than one request bit, only the lowest-index output counts. The other bits are ignored that cycle.
- Per-output FSM, two states:
  - IDLE: the candidate set is the inputs requesting j.
    - Pick the first candidate at or above ptr_j, wrapping modulo N_PORTS.
    - If in_credit_avail[j]=1: grant that input and record it as owner_j.
      - If its in_tail=1: stay IDLE and set ptr_j = owner+1 mod N_PORTS.
      - Otherwise go to LOCKED.
    - If in_credit_avail[j]=0: no grant; stay IDLE; ptr_j unchanged.
  - LOCKED: only owner_j is considered; all other requests for j are ignored.
    - Grant owner_j when it requests j and in_credit_avail[j]=1.
    - If that granted flit has in_tail=1: go to IDLE and set ptr_j = owner_j+1 mod N_PORTS.
    - Owner not requesting, or no credit: no grant; remain LOCKED.
- Conflict freedom: one input requests at most one output after normalisation. Therefore each input receives at most one grant and each output at most one select.
- Latency: decision is combinational on cycle-t inputs and registered at the rising edge. out_grant, out_sel and out_busy reflect that decision during cycle t+1.
- out_busy[j] is registered state, high while LOCKED. In the cycle after a tail grant it returns low together with that grant.
- Grant hold: out_grant and out_sel are single-cycle pulses per decision. Back-to-back flits produce a continuous high level.
- Pointer arithmetic: wrap from N_PORTS-1 to 0. Pointer values >= N_PORTS are unreachable.
- Simultaneous tail release and a new request for the same output: the new packet arbitrates the following cycle. There is no same-cycle handover.

Test Plan:
- Reset then idle: RST 1->0, all inputs 0 -> all outputs 0 for 10 cycles.
- Single-flit: input 2 requests output 4, tail=1, credit=1 -> cycle t+1: out_grant=5'b00100, out_sel[4*5+2]=1, out_busy[4]=0; ptr_4=3.
- Wormhole lock: input 1 sends head, body, tail to output 3 while input 0 also requests output 3 -> input 1 granted 3 consecutive cycles and out_busy[3]=1 during the first two grant cycles; input 0 granted in the cycle after the tail grant.
- Round-robin: inputs 0, 1, 2 all send single-flit packets to output 0 continuously -> grant sequence 0, 1, 2, 0, 1, 2.
- Credit stall: mid-packet, in_credit_avail[3]=0 for 4 cycles -> no grants to the owner and out_busy[3] stays 1; grants resume the cycle after credit returns.
- Async reset mid-packet: RST pulsed between clock edges while output 3 is LOCKED -> out_busy, out_grant and out_sel go to 0 without waiting for a clock edge; the next request wins from ptr=0.
